gsm_tdm_feeder: RTL

- Drives the 320 MHz common data bus of the grouped-shared-memory switch unit.
- Collects 128-bit cells from the four ingress ports, already in the clk_320M domain, into small per-port buffers.
- Time-multiplexes the cells onto the common bus with a rotating one-hot slot select.
- Keeps the slot rotation phase-locked to the 80 MHz ingress control path via a sync pulse; provides per-port occupancy and drop-free backpressure.

---
 rtl/gsm_pkg.sv | 17 +
 rtl/gsm_cell_fifo.sv | 54 +++++
 rtl/gsm_tdm_feeder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/gsm_pkg.sv
// Shared constants and helpers for the grouped-shared-memory switch feeder.
// Slot indices are LOG_MWIDTH wide so the slot counter wraps mod MWIDTH for free.
package gsm_pkg;
  localparam int MWIDTH     = 4;
  localparam int LOG_MWIDTH = 2;
  localparam int DWIDTH     = 128;

  typedef logic [LOG_MWIDTH-1:0] slot_t;

  typedef enum logic {ST_ALIGN, ST_RUN} align_st_e;

  function automatic logic [MWIDTH-1:0] slot_onehot(input slot_t s);
    logic [MWIDTH-1:0] one;
    one = MWIDTH'(1);
    return one << s;
  endfunction
endpackage

// File: rtl/gsm_cell_fifo.sv
// Single-clock cell FIFO with occupancy count; push/pop are self-gated by full/empty.
module gsm_cell_fifo #(
  parameter int DW = 128,
  parameter int AW = 2
) (
  input  logic          clk_320M,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic [AW:0]   count_o,
  output logic          ready_o,
  output logic          empty_o
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  // Ready depends only on the current count: a full FIFO stays not-ready
  // even in a cycle where it is being popped.
  assign ready_o = (count_q != FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ready_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_320M or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_320M) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/gsm_tdm_feeder.sv
// Per-port cell buffering and TDM slot rotation onto the 320 MHz common bus,
// phase-locked to the 80 MHz ingress path by i_phase_sync.
module gsm_tdm_feeder
  import gsm_pkg::*;
#(
  parameter int BUF_AWIDTH = 2,
  parameter int DATA_DELAY = 1
) (
  input  logic                  clk_320M,
  input  logic                  rst_n,
  input  logic                  clr_320M,
  input  logic                  i_phase_sync,
  input  logic [MWIDTH-1:0]     i_cell_valid,
  input  logic [DWIDTH-1:0]     i_cell_data0,
  input  logic [DWIDTH-1:0]     i_cell_data1,
  input  logic [DWIDTH-1:0]     i_cell_data2,
  input  logic [DWIDTH-1:0]     i_cell_data3,
  output logic [MWIDTH-1:0]     o_cell_ready,
  output logic [MWIDTH-1:0]     o_common_sel,
  output logic [DWIDTH-1:0]     o_common_wr_data,
  output logic                  o_common_valid,
  output logic [BUF_AWIDTH:0]   o_buf_count0,
  output logic [BUF_AWIDTH:0]   o_buf_count1,
  output logic [BUF_AWIDTH:0]   o_buf_count2,
  output logic [BUF_AWIDTH:0]   o_buf_count3,
  output logic                  o_sync_err
);
  align_st_e st_q, st_d;
  slot_t     slot_q, slot_d;
  logic      err_q, err_d;

  logic [MWIDTH-1:0][DWIDTH-1:0]   cell_in, head;
  logic [MWIDTH-1:0][BUF_AWIDTH:0] count;
  logic [MWIDTH-1:0]               empty, pop;
  logic                            pop_any;
  logic [DWIDTH-1:0]               pop_data;

  always_comb begin
    st_d   = st_q;
    slot_d = slot_q;
    err_d  = err_q;
    case (st_q)
      ST_ALIGN: begin
        if (i_phase_sync) begin
          st_d   = ST_RUN;
          slot_d = '0;
        end
      end
      ST_RUN: begin
        // A sync landing on the last slot is the expected alignment point and
        // coincides with the natural wrap; anywhere else it is a phase slip.
        if (i_phase_sync && (slot_q != slot_t'(MWIDTH-1))) begin
          err_d  = 1'b1;
          slot_d = '0;
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      default: st_d = ST_ALIGN;
    endcase
  end

  always_ff @(posedge clk_320M or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ST_ALIGN;
      slot_q <= '0;
      err_q  <= 1'b0;
    end else if (clr_320M) begin
      st_q   <= ST_ALIGN;
      slot_q <= '0;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      slot_q <= slot_d;
      err_q  <= err_d;
    end
  end

  assign o_common_sel = (st_q == ST_RUN) ? slot_onehot(slot_q) : '0;
  assign o_sync_err   = err_q;

  assign cell_in = {i_cell_data3, i_cell_data2, i_cell_data1, i_cell_data0};
  assign pop     = o_common_sel & ~empty;
  assign pop_any = |pop;

  for (genvar n = 0; n < MWIDTH; n++) begin : g_port
    gsm_cell_fifo #(.DW(DWIDTH), .AW(BUF_AWIDTH)) u_fifo (
      .clk_320M (clk_320M),
      .rst_n    (rst_n),
      .clr_i    (clr_320M),
      .push_i   (i_cell_valid[n]),
      .data_i   (cell_in[n]),
      .pop_i    (pop[n]),
      .data_o   (head[n]),
      .count_o  (count[n]),
      .ready_o  (o_cell_ready[n]),
      .empty_o  (empty[n])
    );
  end

  always_comb begin
    pop_data = '0;
    if (pop_any) pop_data = head[slot_q];
  end

  if (DATA_DELAY == 0) begin : g_nodly
    assign o_common_wr_data = pop_data;
    assign o_common_valid   = pop_any;
  end else begin : g_dly
    logic [DWIDTH-1:0] data_q;
    logic              vld_q;
    always_ff @(posedge clk_320M or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
        vld_q  <= 1'b0;
      end else if (clr_320M) begin
        data_q <= '0;
        vld_q  <= 1'b0;
      end else begin
        data_q <= pop_data;
        vld_q  <= pop_any;
      end
    end
    assign o_common_wr_data = data_q;
    assign o_common_valid   = vld_q;
  end

  assign o_buf_count0 = count[0];
  assign o_buf_count1 = count[1];
  assign o_buf_count2 = count[2];
  assign o_buf_count3 = count[3];
endmodule
